// File: rtl/ysyx_24110015_mem_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package ysyx_24110015_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   // Data returned to a requester whose transaction the watchdog aborted.
   localparam logic [63:0] TIMEOUT_RDATA = 64'd0;

endpackage

// File: rtl/ysyx_24110015_rr_arb2.sv
// Two-way IFU/LSU arbiter: one-hot grant from the request vector, with either
// fixed LSU priority or round-robin on ties, remembering the last winner.
module ysyx_24110015_rr_arb2
   import ysyx_24110015_mem_pkg::*;
#(
   parameter int LSU_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,     // bit GNT_IFU = IFU, bit GNT_LSU = LSU
   input  logic       update,  // a grant was accepted this cycle
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Tie: favour whichever side did not win last time, unless LSU is fixed-priority.
         2'b11:   gnt = ((LSU_PRIO != 0) || (last_grant == GNT_IFU)) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= GNT_IFU;
      else if (update)
         last_grant <= gnt[GNT_LSU] ? GNT_LSU : GNT_IFU;
   end

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one
// transaction in flight at a time, with a watchdog bounding memory latency.
module ysyx_24110015_mem_arbiter
   import ysyx_24110015_mem_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LSU_PRIO = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            ifu_req_valid,
   output logic            ifu_req_ready,
   input  logic [AW-1:0]   ifu_addr,
   output logic            ifu_resp_valid,
   input  logic            ifu_resp_ready,
   output logic [DW-1:0]   ifu_rdata,

   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [AW-1:0]   lsu_addr,
   input  logic [DW-1:0]   lsu_wdata,
   input  logic            lsu_wen,
   input  logic [DW/8-1:0] lsu_wmask,
   output logic            lsu_resp_valid,
   input  logic            lsu_resp_ready,
   output logic [DW-1:0]   lsu_rdata,

   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic            mem_wen,
   output logic [DW/8-1:0] mem_wmask,
   input  logic            mem_resp_valid,
   input  logic [DW-1:0]   mem_rdata,

   output logic            err_timeout
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t        state, state_n;
   logic          gnt_q;
   logic [1:0]    arb_gnt;
   logic          idle, hs, expire, resp_ready_g;
   logic [CW-1:0] wd_cnt;

   assign idle = (state == IDLE);

   ysyx_24110015_rr_arb2 #(
      .LSU_PRIO (LSU_PRIO)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({lsu_req_valid, ifu_req_valid}),
      .update (hs),
      .gnt    (arb_gnt)
   );

   // A grant only exists when its requester is valid, so any grant in IDLE is a handshake.
   assign ifu_req_ready = idle & arb_gnt[GNT_IFU];
   assign lsu_req_ready = idle & arb_gnt[GNT_LSU];
   assign hs            = idle & (|arb_gnt);

   assign mem_req_valid  = (state == REQ);
   assign ifu_resp_valid = (state == RESP) & (gnt_q == GNT_IFU);
   assign lsu_resp_valid = (state == RESP) & (gnt_q == GNT_LSU);
   assign resp_ready_g   = (gnt_q == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;
   assign expire         = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT));

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (hs) state_n = REQ;
         REQ:     if (mem_req_ready) state_n = WAIT;
         WAIT:    if (mem_resp_valid || expire) state_n = RESP;
         RESP:    if (resp_ready_g) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gnt_q       <= GNT_IFU;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wen     <= 1'b0;
         mem_wmask   <= '0;
         ifu_rdata   <= '0;
         lsu_rdata   <= '0;
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         err_timeout <= 1'b0;

         if (hs) begin
            gnt_q <= arb_gnt[GNT_LSU] ? GNT_LSU : GNT_IFU;
            if (arb_gnt[GNT_LSU]) begin
               mem_addr  <= lsu_addr;
               mem_wdata <= lsu_wdata;
               mem_wen   <= lsu_wen;
               mem_wmask <= lsu_wmask;
            end else begin
               mem_addr  <= ifu_addr;
               mem_wdata <= '0;
               mem_wen   <= 1'b0;
               mem_wmask <= '0;
            end
         end

         // Watchdog: zero outside WAIT, saturating count inside it.
         if (state != WAIT)
            wd_cnt <= '0;
         else if (wd_cnt != '1)
            wd_cnt <= wd_cnt + CW'(1);

         // A response arriving in the expiry cycle takes precedence over the abort.
         if (state == WAIT) begin
            if (mem_resp_valid) begin
               if (gnt_q == GNT_LSU) lsu_rdata <= mem_rdata;
               else                  ifu_rdata <= mem_rdata;
            end else if (expire) begin
               if (gnt_q == GNT_LSU) lsu_rdata <= TIMEOUT_RDATA[DW-1:0];
               else                  ifu_rdata <= TIMEOUT_RDATA[DW-1:0];
               err_timeout <= 1'b1;
            end
         end
      end
   end

   // Memory must not answer in the same cycle it accepts the request.
   a_no_resp_on_accept : assert property (@(posedge clk) disable iff (rst)
      !((state == REQ) && mem_req_ready && mem_resp_valid));

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a table of transactions plus
// hand-written timeout and mid-transaction reset sequences.
module tb_ysyx_24110015_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic          lsu_wen;
   logic [3:0]    lsu_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [3:0]    mem_wmask;
   logic          err_timeout;

   ysyx_24110015_mem_arbiter #(
      .AW(AW), .DW(DW), .LSU_PRIO(0), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ifu_v, lsu_v;
      logic [31:0] ifu_a, lsu_a, wdata;
      logic        wen;
      logic [3:0]  wmask;
      int          stall, lat, hold;
      logic        pester;   // both requesters keep asking while busy
      logic [31:0] rdata;
      logic        exp_lsu;  // expected winner: 1 = LSU, 0 = IFU
   } vec_t;

   vec_t vt[7];
   vec_t vpost;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] ea;
      ea = v.exp_lsu ? v.lsu_a : v.ifu_a;
      ifu_req_valid = v.ifu_v;  lsu_req_valid = v.lsu_v;
      ifu_addr = v.ifu_a;       lsu_addr = v.lsu_a;
      lsu_wdata = v.wdata;      lsu_wen = v.wen;  lsu_wmask = v.wmask;
      #1;
      chk("ifu_req_ready grant", ifu_req_ready, !v.exp_lsu);
      chk("lsu_req_ready grant", lsu_req_ready, v.exp_lsu);
      chk("mem_req_valid idle", mem_req_valid, 0);
      tick();
      ifu_req_valid = v.pester;
      lsu_req_valid = v.pester;
      for (int s = 0; s <= v.stall; s++) begin
         chk("mem_req_valid req", mem_req_valid, 1);
         chk("mem_addr", mem_addr, ea);
         chk("mem_wen", mem_wen, v.exp_lsu ? v.wen : 1'b0);
         chk("mem_wmask", mem_wmask, v.exp_lsu ? v.wmask : 4'h0);
         if (v.exp_lsu) chk("mem_wdata", mem_wdata, v.wdata);
         chk("req_ready busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
         if (s < v.stall) tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("mem_req_valid wait", mem_req_valid, 0);
      for (int l = 0; l < v.lat; l++) begin
         chk("resp_valid during wait", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
         tick();
      end
      mem_resp_valid = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata = 32'h0bad_0bad;
      for (int h = 0; h <= v.hold; h++) begin
         chk("ifu_resp_valid", ifu_resp_valid, !v.exp_lsu);
         chk("lsu_resp_valid", lsu_resp_valid, v.exp_lsu);
         chk("rdata", v.exp_lsu ? lsu_rdata : ifu_rdata, v.rdata);
         chk("err_timeout normal", err_timeout, 0);
         chk("req_ready in resp", {ifu_req_ready, lsu_req_ready}, 2'b00);
         if (h < v.hold) tick();
      end
      if (v.exp_lsu) lsu_resp_ready = 1'b1;
      else           ifu_resp_ready = 1'b1;
      tick();
      ifu_resp_ready = 1'b0;  lsu_resp_ready = 1'b0;
      ifu_req_valid = 1'b0;   lsu_req_valid = 1'b0;
      chk("resp_valid after accept", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      chk("mem_req_valid after accept", mem_req_valid, 0);
   endtask

   initial begin
      int n;
      //         ifu_v lsu_v ifu_a         lsu_a         wdata         wen   wmask stl lat hld pest  rdata         exp_lsu
      vt[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        32'h0,        1'b0, 4'h0, 0,  1,  2,  1'b0, 32'h0000_0413, 1'b0};
      vt[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_0100, 32'h0,       1'b0, 4'hf, 0,  0,  0,  1'b0, 32'h1122_3344, 1'b1};
      vt[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_0100, 32'h0,       1'b0, 4'hf, 1,  1,  0,  1'b0, 32'h0010_0093, 1'b0};
      vt[3] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_1000, 32'hCAFE_BABE, 1'b1, 4'h3, 3,  2,  0,  1'b0, 32'h0,       1'b1};
      vt[4] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_1000, 32'h0,       1'b0, 4'hf, 0,  TO, 0,  1'b0, 32'hDEAD_BEEF, 1'b0};
      vt[5] = '{1'b0, 1'b1, 32'h0,        32'h8000_2000, 32'h0,        1'b0, 4'hf, 0,  1,  5,  1'b1, 32'h55AA_55AA, 1'b1};
      vt[6] = '{1'b1, 1'b0, 32'h8000_000c, 32'h0,        32'h0,        1'b0, 4'h0, 0,  3,  0,  1'b0, 32'h0020_8113, 1'b0};
      vpost = '{1'b0, 1'b1, 32'h0,        32'h8000_3000, 32'h0,        1'b0, 4'hf, 0,  1,  0,  1'b0, 32'h7777_0001, 1'b1};

      rst = 1'b1;
      ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wen = 0; lsu_wmask = 0; lsu_resp_ready = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset valids", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, err_timeout}, 4'b0000);
      chk("reset readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk("reset payload", {mem_addr, mem_wdata}, 64'h0);
      chk("reset rdata", {ifu_rdata, lsu_rdata}, 64'h0);

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // Watchdog abort on an IFU fetch; previous ifu_rdata is nonzero.
      ifu_req_valid = 1'b1;  ifu_addr = 32'h8000_0010;
      #1;
      chk("timeout ifu grant", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      n = 0;
      while (!ifu_resp_valid && n < 20) begin
         chk("err_timeout early", err_timeout, 0);
         tick();
         n++;
      end
      chk("timeout wait cycles", n, TO + 1);
      chk("err_timeout pulse", err_timeout, 1);
      chk("timeout rdata", ifu_rdata, 0);
      tick();
      chk("err_timeout one cycle", err_timeout, 0);
      chk("timeout resp held", ifu_resp_valid, 1);
      ifu_resp_ready = 1'b1;
      tick();
      ifu_resp_ready = 1'b0;
      run_vec(vpost);

      // Reset while in WAIT; a late memory response must be ignored.
      lsu_req_valid = 1'b1;  lsu_addr = 32'h8000_4000;  lsu_wen = 1'b0;  lsu_wmask = 4'hf;
      tick();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst mid valids", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, err_timeout}, 4'b0000);
      chk("rst mid readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk("rst mid payload", mem_addr, 0);
      mem_resp_valid = 1'b1;  mem_rdata = 32'h1234_5678;
      tick();
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("late resp ignored", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 3'b000);
         tick();
      end
      chk("late resp rdata", {ifu_rdata, lsu_rdata}, 64'h0);
      ifu_req_valid = 1'b1;  lsu_req_valid = 1'b1;
      #1;
      chk("last_grant reset tie", {ifu_req_ready, lsu_req_ready}, 2'b01);
      ifu_req_valid = 1'b0;  lsu_req_valid = 1'b0;
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
